// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration.
package mem_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;

  localparam logic [2:0]  ALIGN_MASK = 3'b111;
  localparam int unsigned CNT_W      = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way grant select; prefer_i breaks ties between the requesters.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic prefer_i,
  output logic pick_i,
  output logic pick_d
);

  // Lone requests win outright; simultaneous requests follow prefer_i.
  always_comb begin
    pick_i = 1'b0;
    pick_d = 1'b0;
    if (i_req && d_req) begin
      pick_i = prefer_i;
      pick_d = !prefer_i;
    end else begin
      pick_i = i_req;
      pick_d = d_req;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the IF (read) and MEM (load/store) stages.
// One transaction at a time: IDLE (grant) -> ACCESS (WAIT_CYCLES+1) -> RESP (1 cycle).
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed priority d > i.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err
);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic pick_i, pick_d, prefer_i;
  logic idle_c, last_c, aligned_c, resp_c;

`ifdef MEM_ARB_RR_EN
  arb_owner_t last_owner_q, last_owner_d;
  assign prefer_i = (last_owner_q == OWN_D);
`else
  assign prefer_i = 1'b0;
`endif

  mem_arb_pick u_pick (
    .i_req    (i_req),
    .d_req    (d_req),
    .prefer_i (prefer_i),
    .pick_i   (pick_i),
    .pick_d   (pick_d)
  );

  // Grants only in IDLE; the memory port is driven from the latched request.
  assign idle_c    = (state_q == ARB_IDLE) && !reset;
  assign i_gnt     = idle_c && pick_i;
  assign d_gnt     = idle_c && pick_d;
  assign last_c    = (state_q == ARB_ACCESS) && (cnt_q == '0);
  assign aligned_c = (addr_q[2:0] & ALIGN_MASK) == 3'b000;
  assign mem_we    = we_q && last_c && aligned_c && !reset;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Response pulse goes to the owner only and is suppressed by reset.
  assign resp_c    = (state_q == ARB_RESP) && !reset;
  assign i_rvalid  = resp_c && (owner_q == OWN_I);
  assign d_rvalid  = resp_c && (owner_q == OWN_D);
  assign i_rdata   = rdata_q;
  assign d_rdata   = rdata_q;
  assign i_err     = i_rvalid && err_q;
  assign d_err     = d_rvalid && err_q;

  // Next-state: latch winner on grant, count down ACCESS, capture response on the last cycle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef MEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (i_gnt || d_gnt) begin
          owner_d = d_gnt ? OWN_D : OWN_I;
          we_d    = d_gnt && d_we;
          addr_d  = d_gnt ? d_addr : i_addr;
          wdata_d = d_gnt ? d_wdata : '0;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = ARB_ACCESS;
`ifdef MEM_ARB_RR_EN
          last_owner_d = d_gnt ? OWN_D : OWN_I;
`endif
        end
      end
      ARB_ACCESS: begin
        if (cnt_q == '0) begin
          rdata_d = (we_q || !aligned_c) ? '0 : mem_rdata;
          err_d   = aligned_c ? mem_err : 1'b1;
          state_d = ARB_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // State and latch registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_I;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= OWN_I;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (WAIT_CYCLES 0 and 3) with a transaction-level model.
module tb_mem_port_arbiter;

  localparam logic [63:0] BAD   = 64'h0BAD_0BAD_0BAD_0BAD;
  localparam logic [63:0] LIMIT = 64'h4000;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } op_t;

  logic        clk, reset;
  logic        i_req [2], i_gnt [2], i_rvalid [2], i_err [2];
  logic [63:0] i_addr [2], i_rdata [2];
  logic        d_req [2], d_we [2], d_gnt [2], d_rvalid [2], d_err [2];
  logic [63:0] d_addr [2], d_wdata [2], d_rdata [2];
  logic        mem_we [2], mem_err [2];
  logic [63:0] mem_addr [2], mem_wdata [2], mem_rdata [2];
  logic [63:0] marr [2][2048];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .WAIT_CYCLES(g * 3)) u_dut (
      .clk(clk), .reset(reset),
      .i_req(i_req[g]), .i_addr(i_addr[g]), .i_gnt(i_gnt[g]), .i_rvalid(i_rvalid[g]),
      .i_rdata(i_rdata[g]), .i_err(i_err[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]), .d_err(d_err[g]),
      .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .mem_err(mem_err[g])
    );
    assign mem_err[g]   = mem_addr[g] >= LIMIT;
    assign mem_rdata[g] = mem_err[g] ? BAD : marr[g][mem_addr[g][13:3]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requesters: index n = 2*instance + port (port 0 = IF, 1 = MEM).
  op_t opq [4][$];
  op_t cur [4];
  int  st [4], gap [4];
  bit  s_gnt [4], s_rv [4], prev_rst, rand_gap;

  // Reference model state per instance.
  int          next_free [2], resp_due [2], wr_due [2];
  bit          resp_own [2], resp_err [2], last_own [2];
  logic [63:0] resp_data [2], wr_addr [2], wr_data [2];
  logic [63:0] shadow [2][2048];

  // Observation logs for the hand-computed checks.
  int          lg_gnt_cyc [2], lg_rv_cyc [2], lg_we_cyc [2], we_cnt [2], gcnt [2];
  logic [63:0] lg_rv_data [2];
  bit          lg_rv_err [2];
  logic [7:0]  gseq [2];

  int n_chk, n_fail, cyc;

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc%0d: got %h, expected %h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic push(input int n, input logic we, input logic [63:0] a, input logic [63:0] d);
    op_t o;
    o.we = we; o.addr = a; o.wdata = d;
    opq[n].push_back(o);
  endtask

  task automatic clr_logs();
    for (int k = 0; k < 2; k++) begin
      lg_gnt_cyc[k] = -100; lg_rv_cyc[k] = -100; lg_we_cyc[k] = -100;
      we_cnt[k] = 0; gcnt[k] = 0; gseq[k] = '0; lg_rv_data[k] = 'x; lg_rv_err[k] = 1'b0;
    end
  endtask

  // Transaction-level expectations: the arbiter is free 3+W cycles after a grant,
  // responds at grant+2+W and commits an aligned store at grant+1+W.
  task automatic model_check(input int k, input bit rst);
    int w;
    bit egi, egd, eiv, edv, ewe, wr, al, inr;
    logic [63:0] a;
    w = k * 3;
    egi = 0; egd = 0; eiv = 0; edv = 0; ewe = 0;
    if (rst) begin
      resp_due[k] = -1; wr_due[k] = -1; next_free[k] = cyc + 1; last_own[k] = 0;
    end else begin
      ewe = (wr_due[k] == cyc);
      eiv = (resp_due[k] == cyc) && !resp_own[k];
      edv = (resp_due[k] == cyc) && resp_own[k];
      if (cyc >= next_free[k]) begin
`ifdef MEM_ARB_RR_EN
        if (i_req[k] && d_req[k]) egd = !last_own[k];
        else                      egd = d_req[k];
`else
        egd = d_req[k];
`endif
        egi = i_req[k] && !egd;
      end
    end
    chk("i_gnt", k, 64'(i_gnt[k]), 64'(egi));
    chk("d_gnt", k, 64'(d_gnt[k]), 64'(egd));
    chk("i_rvalid", k, 64'(i_rvalid[k]), 64'(eiv));
    chk("d_rvalid", k, 64'(d_rvalid[k]), 64'(edv));
    chk("mem_we", k, 64'(mem_we[k]), 64'(ewe));
    if (ewe) begin
      chk("mem_addr", k, mem_addr[k], wr_addr[k]);
      chk("mem_wdata", k, mem_wdata[k], wr_data[k]);
      if (wr_addr[k] < LIMIT) shadow[k][wr_addr[k][13:3]] = wr_data[k];
    end
    if (eiv) begin
      chk("i_rdata", k, i_rdata[k], resp_data[k]);
      chk("i_err", k, 64'(i_err[k]), 64'(resp_err[k]));
    end
    if (edv) begin
      chk("d_rdata", k, d_rdata[k], resp_data[k]);
      chk("d_err", k, 64'(d_err[k]), 64'(resp_err[k]));
    end
    if (egi || egd) begin
      a  = egd ? d_addr[k] : i_addr[k];
      wr = egd && d_we[k];
      al = (a[2:0] == 3'b000);
      inr = (a < LIMIT);
      next_free[k] = cyc + 3 + w;
      resp_due[k]  = cyc + 2 + w;
      resp_own[k]  = egd;
      last_own[k]  = egd;
      if (!al) begin
        resp_data[k] = '0; resp_err[k] = 1'b1;
      end else begin
        resp_err[k]  = !inr;
        resp_data[k] = wr ? 64'h0 : (inr ? shadow[k][a[13:3]] : BAD);
      end
      if (wr && al) begin
        wr_due[k] = cyc + 1 + w; wr_addr[k] = a; wr_data[k] = d_wdata[k];
      end
    end
    // Logs and the memory device itself react to what the DUT actually drives.
    if (i_gnt[k] || d_gnt[k]) begin
      lg_gnt_cyc[k] = cyc; gseq[k] = {gseq[k][6:0], d_gnt[k]}; gcnt[k]++;
    end
    if (i_rvalid[k] || d_rvalid[k]) begin
      lg_rv_cyc[k]  = cyc;
      lg_rv_data[k] = d_rvalid[k] ? d_rdata[k] : i_rdata[k];
      lg_rv_err[k]  = d_rvalid[k] ? d_err[k] : i_err[k];
    end
    if (mem_we[k]) begin
      we_cnt[k]++; lg_we_cyc[k] = cyc;
      if (mem_addr[k] < LIMIT) marr[k][mem_addr[k][13:3]] = mem_wdata[k];
    end
  endtask

  task automatic cycle(input bit rst);
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      if (prev_rst) begin
        if (st[n] == 2) begin opq[n].push_front(cur[n]); st[n] = 0; gap[n] = 1; end
      end else if (st[n] == 1 && s_gnt[n]) begin
        st[n] = 2;
      end else if (st[n] == 2 && s_rv[n]) begin
        st[n] = 0; gap[n] = rand_gap ? int'($urandom_range(2)) : 0;
      end
      if (st[n] == 0) begin
        if (gap[n] > 0) gap[n]--;
        else if (opq[n].size() > 0) begin cur[n] = opq[n].pop_front(); st[n] = 1; end
      end
    end
    reset = rst;
    for (int k = 0; k < 2; k++) begin
      i_req[k]   = (st[2*k] == 1);
      i_addr[k]  = cur[2*k].addr;
      d_req[k]   = (st[2*k+1] == 1);
      d_we[k]    = cur[2*k+1].we;
      d_addr[k]  = cur[2*k+1].addr;
      d_wdata[k] = cur[2*k+1].wdata;
    end
    #3;
    for (int k = 0; k < 2; k++) model_check(k, rst);
    for (int k = 0; k < 2; k++) begin
      s_gnt[2*k] = i_gnt[k]; s_gnt[2*k+1] = d_gnt[k];
      s_rv[2*k]  = i_rvalid[k]; s_rv[2*k+1] = d_rvalid[k];
    end
    prev_rst = rst;
    cyc++;
  endtask

  function automatic bit busy();
    for (int n = 0; n < 4; n++) if (opq[n].size() != 0 || st[n] != 0) return 1'b1;
    for (int k = 0; k < 2; k++) if (cyc < next_free[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_quiet(input int maxc);
    int c;
    c = 0;
    do begin cycle(1'b0); c++; end while (busy() && c < maxc);
    chk("quiet_timeout", 0, 64'(busy()), 64'h0);
  endtask

  task automatic push_rand(input int n);
    int r;
    logic [63:0] a;
    r = int'($urandom_range(9));
    if (r <= 5)      a = 64'h2000 + 64'($urandom_range(15)) * 8;
    else if (r == 6) a = 64'h1000;
    else if (r == 7) a = 64'h2000 + 64'($urandom_range(7, 1));
    else             a = 64'h8000 + 64'($urandom_range(3)) * 8;
    push(n, (n % 2 == 1) ? 1'($urandom_range(1)) : 1'b0, a, {$urandom(), $urandom()});
  endtask

  initial begin
    logic [3:0] exp_seq;
    int c;
    bit hit;
    reset = 1'b1; prev_rst = 1'b0; rand_gap = 1'b0;
    n_chk = 0; n_fail = 0; cyc = 0;
    for (int n = 0; n < 4; n++) begin
      st[n] = 0; gap[n] = 0; s_gnt[n] = 0; s_rv[n] = 0;
      cur[n].we = 1'b0; cur[n].addr = '0; cur[n].wdata = '0;
    end
    for (int k = 0; k < 2; k++) begin
      next_free[k] = 0; resp_due[k] = -1; wr_due[k] = -1; last_own[k] = 0;
      for (int i = 0; i < 2048; i++) begin
        marr[k][i] = {32'hA5A5_0000, 32'(i)};
        shadow[k][i] = marr[k][i];
      end
      marr[k][11'h200] = 64'hDEADBEEF_00000001; shadow[k][11'h200] = 64'hDEADBEEF_00000001;
      marr[k][11'h401] = 64'h0;                 shadow[k][11'h401] = 64'h0;
    end
    repeat (3) cycle(1'b1);

    // Lone IF read of 0x1000.
    clr_logs();
    push(0, 1'b0, 64'h1000, 64'h0); push(2, 1'b0, 64'h1000, 64'h0);
    run_quiet(40);
    for (int k = 0; k < 2; k++) begin
      chk("if_latency", k, 64'(lg_rv_cyc[k] - lg_gnt_cyc[k]), 64'(2 + 3 * k));
      chk("if_rdata", k, lg_rv_data[k], 64'hDEADBEEF_00000001);
      chk("if_err", k, 64'(lg_rv_err[k]), 64'h0);
    end

    // Store 0x55 to 0x2000, then load it back.
    clr_logs();
    push(1, 1'b1, 64'h2000, 64'h55); push(3, 1'b1, 64'h2000, 64'h55);
    run_quiet(40);
    for (int k = 0; k < 2; k++) begin
      chk("st_we_count", k, 64'(we_cnt[k]), 64'h1);
      chk("st_we_last_cycle", k, 64'(lg_we_cyc[k] - lg_gnt_cyc[k]), 64'(1 + 3 * k));
      chk("st_rdata_zero", k, lg_rv_data[k], 64'h0);
      chk("st_latency", k, 64'(lg_rv_cyc[k] - lg_gnt_cyc[k]), 64'(2 + 3 * k));
    end
    clr_logs();
    push(1, 1'b0, 64'h2000, 64'h0); push(3, 1'b0, 64'h2000, 64'h0);
    run_quiet(40);
    for (int k = 0; k < 2; k++) chk("ld_after_st", k, lg_rv_data[k], 64'h55);

    // Both requesters held: grant order after reset (last owner = IF).
    repeat (2) cycle(1'b1);
    clr_logs();
    for (int n = 0; n < 4; n++) begin
      push(n, 1'b0, (n % 2 == 1) ? 64'h2000 : 64'h1000, 64'h0);
      push(n, 1'b0, (n % 2 == 1) ? 64'h2000 : 64'h1000, 64'h0);
    end
    run_quiet(80);
`ifdef MEM_ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b1100;
`endif
    for (int k = 0; k < 2; k++) begin
      chk("grant_count", k, 64'(gcnt[k]), 64'h4);
      chk("grant_order", k, 64'(gseq[k][3:0]), 64'(exp_seq));
    end

    // Misaligned load: error, zero data, no write, same latency.
    clr_logs();
    push(1, 1'b0, 64'h1003, 64'h0); push(3, 1'b0, 64'h1003, 64'h0);
    run_quiet(40);
    for (int k = 0; k < 2; k++) begin
      chk("mis_err", k, 64'(lg_rv_err[k]), 64'h1);
      chk("mis_rdata", k, lg_rv_data[k], 64'h0);
      chk("mis_no_we", k, 64'(we_cnt[k]), 64'h0);
      chk("mis_latency", k, 64'(lg_rv_cyc[k] - lg_gnt_cyc[k]), 64'(2 + 3 * k));
    end

    // Reset in the commit cycle of a store on the slow instance.
    clr_logs();
    push(1, 1'b1, 64'h2008, 64'hAA); push(3, 1'b1, 64'h2008, 64'hAA);
    c = 0; hit = 1'b0;
    while (!hit && c < 50) begin
      if (wr_due[1] == cyc) begin cycle(1'b1); hit = 1'b1; end
      else cycle(1'b0);
      c++;
    end
    chk("rst_commit_reached", 1, 64'(hit), 64'h1);
    cycle(1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("post_rst_gnt", k, 64'({i_gnt[k], d_gnt[k]}), 64'h0);
      chk("post_rst_rvalid", k, 64'({i_rvalid[k], d_rvalid[k]}), 64'h0);
      chk("post_rst_we", k, 64'(mem_we[k]), 64'h0);
      chk("post_rst_rdata", k, i_rdata[k] | d_rdata[k], 64'h0);
      chk("post_rst_err", k, 64'({i_err[k], d_err[k]}), 64'h0);
      chk("post_rst_maddr", k, mem_addr[k] | mem_wdata[k], 64'h0);
    end
    chk("rst_no_write", 1, marr[1][11'h401], 64'h0);
    run_quiet(40);
    chk("reissue_write", 1, marr[1][11'h401], 64'hAA);
    chk("reissue_err", 1, 64'(lg_rv_err[1]), 64'h0);

    // Randomized traffic with occasional resets.
    rand_gap = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      for (int n = 0; n < 4; n++)
        if (opq[n].size() == 0 && st[n] == 0 && $urandom_range(3) == 0) push_rand(n);
      cycle($urandom_range(199) == 0);
    end
    rand_gap = 1'b0;
    run_quiet(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
